adder_xbit_arbiter: RTL

Shares one `adder_xbit_ahead` instance among `REQ_NUM` requesters. Each requester presents operands and a carry-in over a valid/ready channel. Requests are granted round-robin, one operation is sequenced through the adder at a time, and the sum is returned on a single shared response channel tagged with the requester ID. The block sits between the execution-unit clients and the common adder, so one carry-lookahead datapath serves several ports.

---
 rtl/adder_xbit_arbiter_if.sv | 30 +++
 rtl/adder_xbit_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_xbit_arbiter_if.sv
// adder_xbit_arbiter_if: request/response bundle between the adder clients and the shared adder arbiter.
interface adder_xbit_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned ID_WIDTH   = $clog2(REQ_NUM)
) ();
  logic [REQ_NUM-1:0]            i_req_vld;
  logic [REQ_NUM-1:0]            o_req_rdy;
  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_num_a;
  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_num_b;
  logic [REQ_NUM-1:0]            i_req_cry;
  logic                          o_rsp_vld;
  logic                          i_rsp_rdy;
  logic [DATA_WIDTH-1:0]         o_rsp_res;
  logic                          o_rsp_cry;
  logic [ID_WIDTH-1:0]           o_rsp_id;
  logic                          o_busy;

  // client side: drives requests, accepts responses
  modport master (
    output i_req_vld, i_req_num_a, i_req_num_b, i_req_cry, i_rsp_rdy,
    input  o_req_rdy, o_rsp_vld, o_rsp_res, o_rsp_cry, o_rsp_id, o_busy
  );

  // arbiter side
  modport slave (
    input  i_req_vld, i_req_num_a, i_req_num_b, i_req_cry, i_rsp_rdy,
    output o_req_rdy, o_rsp_vld, o_rsp_res, o_rsp_cry, o_rsp_id, o_busy
  );
endinterface

// File: rtl/adder_xbit_arbiter.sv
// adder_xbit_arbiter: round-robin arbiter sharing one carry-lookahead adder among REQ_NUM requesters.
// Build option: define ADDER_ARB_BYPASS_EN to drop the CALC state and feed the adder from the
// granted requester's live operands (latency T+1 instead of T+2, no operand registers).

module adder_xbit_ahead #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
);
  logic [DATA_WIDTH-1:0] gen_c;
  logic [DATA_WIDTH-1:0] prp_c;
  logic [DATA_WIDTH:0]   cry_c;

  // generate/propagate terms and lookahead carries
  always_comb begin
    gen_c    = i_num_a & i_num_b;
    prp_c    = i_num_a ^ i_num_b;
    cry_c    = '0;
    cry_c[0] = i_cry;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      cry_c[i+1] = gen_c[i] | (prp_c[i] & cry_c[i]);
    end
  end

  assign o_res = prp_c ^ cry_c[DATA_WIDTH-1:0];
  assign o_cry = cry_c[DATA_WIDTH];
endmodule

module adder_xbit_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned ID_WIDTH   = $clog2(REQ_NUM)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  adder_xbit_arbiter_if.slave bus
);
  // one extra bit so last+offset can exceed REQ_NUM before wrapping
  localparam int unsigned CW = ID_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifndef ADDER_ARB_BYPASS_EN
    ST_CALC = 2'd1,
`endif
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  cry_q, cry_d;
`ifndef ADDER_ARB_BYPASS_EN
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  op_cry_q, op_cry_d;
`endif

  logic                  grant_vld_c;
  logic [ID_WIDTH-1:0]   grant_id_c;
  logic                  xfer_c;
  logic [REQ_NUM-1:0]    req_rdy_c;
  logic [DATA_WIDTH-1:0] sel_a_c, sel_b_c;
  logic                  sel_cry_c;
  logic [DATA_WIDTH-1:0] add_a_c, add_b_c, sum_res_c;
  logic                  add_cry_c, sum_cry_c;

  // round-robin search: first valid requester after the last one granted
  always_comb begin
    logic [CW-1:0] cand;
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= REQ_NUM; k++) begin
      cand = {1'b0, last_q} + CW'(k);
      if (cand >= CW'(REQ_NUM)) begin
        cand = cand - CW'(REQ_NUM);
      end
      if (!grant_vld_c && bus.i_req_vld[cand[ID_WIDTH-1:0]]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = cand[ID_WIDTH-1:0];
      end
    end
  end

  // one-hot accept (IDLE only) and operand slice of the granted requester
  always_comb begin
    req_rdy_c = '0;
    sel_a_c   = '0;
    sel_b_c   = '0;
    sel_cry_c = 1'b0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (grant_id_c == ID_WIDTH'(k)) begin
        sel_a_c      = bus.i_req_num_a[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b_c      = bus.i_req_num_b[k*DATA_WIDTH +: DATA_WIDTH];
        sel_cry_c    = bus.i_req_cry[k];
        req_rdy_c[k] = grant_vld_c && (state_q == ST_IDLE);
      end
    end
  end

  assign xfer_c = grant_vld_c && (state_q == ST_IDLE);

  // adder operand source: live slice when bypassing, captured operands otherwise
  always_comb begin
`ifdef ADDER_ARB_BYPASS_EN
    add_a_c   = sel_a_c;
    add_b_c   = sel_b_c;
    add_cry_c = sel_cry_c;
`else
    add_a_c   = op_a_q;
    add_b_c   = op_b_q;
    add_cry_c = op_cry_q;
`endif
  end

  adder_xbit_ahead #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .i_num_a (add_a_c),
    .i_num_b (add_b_c),
    .i_cry   (add_cry_c),
    .o_res   (sum_res_c),
    .o_cry   (sum_cry_c)
  );

  // state and datapath registers; reset drops any in-flight operation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      last_q   <= ID_WIDTH'(REQ_NUM - 1);
      id_q     <= '0;
      res_q    <= '0;
      cry_q    <= 1'b0;
`ifndef ADDER_ARB_BYPASS_EN
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cry_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      res_q    <= res_d;
      cry_q    <= cry_d;
`ifndef ADDER_ARB_BYPASS_EN
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_cry_q <= op_cry_d;
`endif
    end
  end

  // next-state and register updates
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    res_d    = res_q;
    cry_d    = cry_q;
`ifndef ADDER_ARB_BYPASS_EN
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_cry_d = op_cry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (xfer_c) begin
          last_d = grant_id_c;
          id_d   = grant_id_c;
`ifdef ADDER_ARB_BYPASS_EN
          res_d   = sum_res_c;
          cry_d   = sum_cry_c;
          state_d = ST_RESP;
`else
          op_a_d   = sel_a_c;
          op_b_d   = sel_b_c;
          op_cry_d = sel_cry_c;
          state_d  = ST_CALC;
`endif
        end
      end
`ifndef ADDER_ARB_BYPASS_EN
      ST_CALC: begin
        res_d   = sum_res_c;
        cry_d   = sum_cry_c;
        state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (bus.i_rsp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_req_rdy = req_rdy_c;
  assign bus.o_rsp_vld = (state_q == ST_RESP);
  assign bus.o_rsp_res = res_q;
  assign bus.o_rsp_cry = cry_q;
  assign bus.o_rsp_id  = id_q;
  assign bus.o_busy    = (state_q != ST_IDLE);
endmodule
